// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared types and sizing helpers for the LCE response arbiter.
// The grant width is a macro so that it can size ANSI port declarations.
`ifndef BP_RESP_ARB_GRANT_WIDTH_DEFINED
`define BP_RESP_ARB_GRANT_WIDTH_DEFINED
`define BP_RESP_ARB_GRANT_WIDTH(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package bp_common_pkg;

  typedef enum logic [0:0] {
    e_resp_arb_fixed = 1'b0,
    e_resp_arb_rr    = 1'b1
  } bp_resp_arb_mode_e;

  localparam int lce_cce_resp_width_lp = 64;

endpackage

// File: rtl/bp_lce_resp_arb_fifo.sv
// bp_lce_resp_arb_fifo: 1r1w buffer, valid/ready in, valid/yumi out.
// ready_o is the not-full flag only; a same-cycle pop does not raise it.
module bp_lce_resp_arb_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_rptr;
  logic [ptr_w_lp-1:0] r_wptr;
  logic [cnt_w_lp-1:0] r_cnt;
  logic                w_enq;
  logic                w_deq;

  function automatic logic [ptr_w_lp-1:0] f_inc(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = (r_cnt != cnt_w_lp'(els_p));
  assign v_o     = (r_cnt != '0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= f_inc(r_wptr);
      if (w_deq) r_rptr <= f_inc(r_rptr);
      if (w_enq & ~w_deq)
        r_cnt <= r_cnt + cnt_w_lp'(1);
      else if (w_deq & ~w_enq)
        r_cnt <= r_cnt - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bp_lce_resp_arbiter.sv
// bp_lce_resp_arbiter: merges per-source LCE responses onto one lce_resp
// channel; fixed priority with starvation guard or round robin, lock on stall.
module bp_lce_resp_arbiter
  import bp_common_pkg::*;
#(
  parameter int num_src_p      = 2,
  parameter int msg_width_p    = lce_cce_resp_width_lp,
  parameter int fifo_els_p     = 2,
  parameter int rr_mode_p      = 0,
  parameter int starve_limit_p = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_src_p*msg_width_p-1:0]    msg_i,
  input  logic [num_src_p-1:0]                v_i,
  output logic [num_src_p-1:0]                ready_o,
  output logic [msg_width_p-1:0]              lce_resp_o,
  output logic                                lce_resp_v_o,
  input  logic                                lce_resp_ready_i,
  output logic [`BP_RESP_ARB_GRANT_WIDTH(num_src_p)-1:0] grant_id_o
);

  localparam int gw_lp = `BP_RESP_ARB_GRANT_WIDTH(num_src_p);
  localparam int cw_lp = $clog2(starve_limit_p + 1);
  localparam bit rr_lp = (rr_mode_p == int'(e_resp_arb_rr));
  localparam logic [cw_lp-1:0] lim_lp  = cw_lp'(starve_limit_p);
  localparam logic [gw_lp-1:0] last_lp = gw_lp'(num_src_p - 1);

  logic [num_src_p-1:0]   w_fifo_v;
  logic [num_src_p-1:0]   w_fifo_ready;
  logic [num_src_p-1:0]   w_yumi;
  logic [num_src_p-1:0]   w_starved;
  logic [msg_width_p-1:0] w_head [num_src_p];
  logic [gw_lp-1:0]       w_fix_sel;
  logic [gw_lp-1:0]       w_rr_sel;
  logic [gw_lp-1:0]       w_grant;
  logic                   w_v;
  logic                   w_hs;

  logic                   r_lock;
  logic [gw_lp-1:0]       r_grant;
  logic [gw_lp-1:0]       r_rr;
  logic [cw_lp-1:0]       r_wait [num_src_p];

  for (genvar k = 0; k < num_src_p; k++) begin : g_src
    bp_lce_resp_arb_fifo #(
      .width_p(msg_width_p),
      .els_p  (fifo_els_p)
    ) u_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .data_i (msg_i[k*msg_width_p +: msg_width_p]),
      .v_i    (v_i[k] & ~reset_i),
      .ready_o(w_fifo_ready[k]),
      .data_o (w_head[k]),
      .v_o    (w_fifo_v[k]),
      .yumi_i (w_yumi[k])
    );
    assign w_starved[k] = (r_wait[k] == lim_lp);
  end

  // Descending scans: the last hit is the lowest index / nearest to r_rr.
  always_comb begin
    w_fix_sel = '0;
    for (int k = num_src_p - 1; k >= 0; k--)
      if (w_fifo_v[k]) w_fix_sel = gw_lp'(k);
    for (int k = num_src_p - 1; k >= 0; k--)
      if (w_fifo_v[k] && w_starved[k]) w_fix_sel = gw_lp'(k);
    w_rr_sel = '0;
    for (int j = num_src_p - 1; j >= 0; j--)
      if (w_fifo_v[(int'(r_rr) + j) % num_src_p])
        w_rr_sel = gw_lp'((int'(r_rr) + j) % num_src_p);
  end

  always_comb begin
    if (r_lock)
      w_grant = r_grant;
    else
      w_grant = rr_lp ? w_rr_sel : w_fix_sel;
  end

  assign w_v  = (|w_fifo_v) & ~reset_i;
  assign w_hs = w_v & lce_resp_ready_i;

  always_comb begin
    w_yumi = '0;
    if (w_hs) w_yumi[w_grant] = 1'b1;
  end

  assign ready_o      = w_fifo_ready & {num_src_p{~reset_i}};
  assign lce_resp_v_o = w_v;
  assign lce_resp_o   = w_v ? w_head[w_grant] : '0;
  assign grant_id_o   = w_v ? w_grant : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lock  <= 1'b0;
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      r_lock  <= w_v & ~lce_resp_ready_i;
      r_grant <= w_grant;
      if (w_hs)
        r_rr <= (w_grant == last_lp) ? '0 : w_grant + gw_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < num_src_p; k++) begin
      if (reset_i || !w_fifo_v[k] || w_yumi[k])
        r_wait[k] <= '0;
      else if (r_wait[k] != lim_lp)
        r_wait[k] <= r_wait[k] + cw_lp'(1);
    end
  end

endmodule

// File: doc/bp_lce_resp_arbiter.md
# bp_lce_resp_arbiter

Parametrised N-source arbiter for LCE-to-CCE response traffic. It merges response messages from several LCE sub-units (request engine, command engine, writeback/eviction engines) onto one `lce_resp` channel. Each source has its own input buffer. Arbitration is selectable between fixed priority with starvation protection and round robin. An offered message stays locked until it is accepted. It replaces the single-cycle two-way priority mux in the LCE top level and lets I-cache and D-cache LCEs share one arbiter.

## Interface
Parameters:
- `num_src_p`, 2: number of response sources; minimum 1.
- `msg_width_p`, `lce_cce_resp_width_lp`: width of one response message.
- `fifo_els_p`, 2: depth of each per-source buffer; minimum 2.
- `rr_mode_p`, 0: 0 selects fixed priority (index 0 highest) with starvation guard; 1 selects round robin.
- `starve_limit_p`, 8: in fixed mode, the number of waiting cycles after which a source is forced to win; minimum 1.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `msg_i`, in, `num_src_p*msg_width_p`: source k occupies bits [k*msg_width_p +: msg_width_p].
- `v_i`, in, `num_src_p`: per-source valid.
- `ready_o`, out, `num_src_p`: per-source ready. Source k transfers when `v_i[k] & ready_o[k]`.
- `lce_resp_o`, out, `msg_width_p`: arbitrated message.
- `lce_resp_v_o`, out, 1: output valid.
- `lce_resp_ready_i`, in, 1: downstream ready. A message transfers when `lce_resp_v_o & lce_resp_ready_i`.
- `grant_id_o`, out, `BSG_SAFE_CLOG2(num_src_p)`: index of the source currently on `lce_resp_o`. Meaningful only while `lce_resp_v_o` is high.

## Operation
- **Input buffers.** Each source enqueues into its own FIFO of depth `fifo_els_p`.
  - `ready_o[k]` is the FIFO-not-full flag only. There is no bypass, and a dequeue in the same cycle does not raise `ready_o`.
  - Enqueue and dequeue in the same cycle are both legal. The occupancy count is unchanged.
- **Candidates.** The candidate set is the set of non-empty FIFO heads. `lce_resp_v_o` is the OR of all candidates.
- **Lock.** When `lce_resp_v_o` is high and `lce_resp_ready_i` is low, `grant_id_o` and `lce_resp_o` must stay unchanged next cycle. This holds even if a higher-priority source becomes valid. The lock releases on handshake.
- **Round-robin mode.**
  - Pointer `rr_r` starts at 0.
  - The grant goes to the first candidate at or after `rr_r`, searching modulo `num_src_p`.
  - On handshake, `rr_r` becomes grant+1, wrapping from `num_src_p`-1 to 0.
- **Fixed mode.**
  - Each source has a counter `wait_r[k]` that saturates at `starve_limit_p`.
  - The counter increments in every cycle the source's head is valid and not dequeued.
  - The counter clears on that source's dequeue, or while its FIFO is empty.
  - If any unlocked candidate has `wait_r` equal to `starve_limit_p`, the lowest-indexed such source wins. Otherwise the lowest-indexed candidate wins.
- **Dequeue.** Only the granted FIFO pops, and only on handshake. At most one message leaves per cycle.
- **`num_src_p` = 1.** The block degenerates to a single FIFO. `grant_id_o` is held at 0.

## Timing
- **Reset.**
  - All FIFOs flush and any in-flight message is dropped.
  - `ready_o` = 0 and `lce_resp_v_o` = 0 during reset. `ready_o` rises in the first cycle after reset deasserts.
  - `grant_id_o` = 0, `lce_resp_o` = 0, `rr_r` = 0, all `wait_r` = 0, and the lock is cleared.
  - Reset asserted in the middle of a lock discards the locked message without a handshake.
- **Latency.**
  - A message enqueued in cycle t is visible on `lce_resp_o` in cycle t+1 at the earliest.
  - Output valid, data and grant are combinational from the FIFO heads and registered state. `lce_resp_ready_i` reaches only the pop logic, with no path to `lce_resp_v_o`.
- **Throughput.** One message per cycle while any FIFO is non-empty and `lce_resp_ready_i` is high.
- **Worst-case wait in fixed mode.** `starve_limit_p` plus (`num_src_p`-1) plus the lock duration.
- **Full FIFO.** With `fifo_els_p` messages held, `ready_o` = 0. It returns to 1 in the cycle after a pop.

## Structure
- Shared package `bp_common_pkg` holds:
  - enum `bp_resp_arb_mode_e`: `e_resp_arb_fixed` = 0, `e_resp_arb_rr` = 1.
  - a width macro `bp_resp_arb_grant_width(n)`.
- Sub-module: `bp_lce_resp_arb_fifo`, a parametrised 1r1w FIFO with valid/ready on input and valid/yumi on output, instantiated once per source with a generate loop.
- The grant, lock, round-robin pointer and starvation counters live in the top module. The LCE top instantiates the arbiter with `num_src_p` = 2: source 0 is the request engine and source 1 is the command engine.

## Test plan
- **Fixed, contention.** Fixed mode, `starve_limit_p` = 4. Sources 0 and 1 are valid every cycle and `lce_resp_ready_i` is held at 1.
  - Required: grants 0,0,0,0, then 1 in the fifth cycle (starvation force), then the pattern repeats.
  - Required: no message is lost or reordered within a source.
- **Round robin, all sources.** Round-robin mode, `num_src_p` = 3, all sources continuously valid. Required: the grant sequence is 0,1,2,0,1,2.
- **Lock under backpressure.** Source 1 is valid and `lce_resp_ready_i` = 0 for 5 cycles; source 0 becomes valid in cycle 2. Required: `grant_id_o` = 1 and `lce_resp_o` stay stable throughout, and source 0 is granted in the cycle after source 1's handshake.
- **Full buffer.** `fifo_els_p` = 2 and `lce_resp_ready_i` = 0. Source 0 pushes 3 messages A, B, C.
  - Required: `ready_o[0]` drops after B, and C stalls.
  - Then raise `lce_resp_ready_i`. Required: output A, B, C in order, with `ready_o[0]` rising the cycle after A pops.
- **Reset mid-operation.** Assert `reset_i` while both FIFOs hold 2 messages and the output is locked.
  - Required: in the next cycle `lce_resp_v_o` = 0 and all FIFOs are empty.
  - Required: after reset, a new message on source 1 appears one cycle after enqueue with `grant_id_o` = 1.
